// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control FSM for a shared instruction/data memory.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   Op, funct3, funct7b5, Zero, mem_ready - decode and status inputs
//   PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc - enables and address select
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl - datapath mux/ALU controls
//   instr_done, illegal, state - completion, trap flag and debug state
module mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7,
    ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_B = 7'b1100011, OP_J = 7'b1101111;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FN = 2'b10;
  state_t st;
  logic [1:0] alu_op;
  logic pc_w, ir_w, reg_w, mem_w, done, ill;
  always_ff @(posedge clk) begin
    if (rst) st <= FETCH;
    else begin
      case (st)
        FETCH:    st <= mem_ready ? DECODE : FETCH;
        DECODE:   st <= (Op == OP_LW || Op == OP_SW) ? MEMADR :
                        Op == OP_R ? EXECUTER : Op == OP_I ? EXECUTEI :
                        Op == OP_B ? BEQ : Op == OP_J ? JAL : TRAP;
        MEMADR:   st <= (Op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  st <= mem_ready ? MEMWB : MEMREAD;
        MEMWRITE: st <= mem_ready ? FETCH : MEMWRITE;
        EXECUTER, EXECUTEI, JAL: st <= ALUWB;
        TRAP:     st <= TRAP;
        default:  st <= FETCH;
      endcase
    end
  end
  always_comb begin
    pc_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    done = 1'b0;
    ill = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    alu_op = ALU_ADD;
    case (st)
      FETCH: begin
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        ir_w = mem_ready;
        pc_w = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w = 1'b1;
        done = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w = 1'b1;
        done = mem_ready;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op = ALU_FN;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op = ALU_FN;
      end
      ALUWB: begin
        reg_w = 1'b1;
        done = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op = ALU_SUB;
        pc_w = Zero;
        done = 1'b1;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w = 1'b1;
      end
      TRAP: ill = 1'b1;
      default: ;
    endcase
  end
  // Subtract only for R-type (Op[5]=1) with funct7b5; addi ignores funct7b5.
  assign ALUControl = alu_op == ALU_SUB ? 3'b001 :
                      alu_op == ALU_ADD ? 3'b000 :
                      funct3 == 3'b000 ? {2'b00, funct7b5 & Op[5]} :
                      funct3 == 3'b010 ? 3'b101 :
                      funct3 == 3'b110 ? 3'b011 :
                      funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign ImmSrc = Op == OP_SW ? 2'b01 : Op == OP_B ? 2'b10 : Op == OP_J ? 2'b11 : 2'b00;
  // Reset masks every side-effecting output combinationally, even mid-MEMWRITE.
  assign PCWrite = pc_w & ~rst;
  assign IRWrite = ir_w & ~rst;
  assign RegWrite = reg_w & ~rst;
  assign MemWrite = mem_w & ~rst;
  assign instr_done = done & ~rst;
  assign illegal = ill & ~rst;
  assign state = st;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed scoreboard bench for mc_controller.
module tb_mc_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] Op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic funct7b5 = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, instr_done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  mc_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JP = 7'b1101111, IL = 7'b1111111;
  typedef struct {
    int id;
    logic [21:0] v;
  } exp_t;
  exp_t q[$];
  int n_run = 0, n_fail = 0, step = 0;
  logic [21:0] act;
  assign act = {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, ALUControl, instr_done, illegal};
  // en = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc}; di = {instr_done, illegal}
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic f7, z, mr, r,
                     input logic [3:0] st, input logic [4:0] en, input logic [1:0] rs, sa, sb,
                     im, input logic [2:0] ac, input logic [1:0] di);
    @(posedge clk);
    #1;
    Op = op;
    funct3 = f3;
    funct7b5 = f7;
    Zero = z;
    mem_ready = mr;
    rst = r;
    q.push_back('{step, {st, en, rs, sa, sb, im, ac, di}});
    step++;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_run++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL step%0d {st,en,rs,sa,sb,im,ac,di}: got %b want %b", e.id, act, e.v);
      end
    end
  end
  initial begin
    // reset held: FETCH muxes, enables masked
    cyc(LW, 3'b000, 0, 0, 1, 1, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    // lw: 0,1,2,3,4
    cyc(LW, 3'b010, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc(LW, 3'b010, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00);
    cyc(LW, 3'b010, 0, 0, 1, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00);
    cyc(LW, 3'b010, 0, 0, 1, 0, 4'd3, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc(LW, 3'b010, 0, 0, 1, 0, 4'd4, 5'b00100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
    // sub
    cyc(RT, 3'b000, 1, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc(RT, 3'b000, 1, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00);
    cyc(RT, 3'b000, 1, 0, 1, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00);
    cyc(RT, 3'b000, 1, 0, 1, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
    // add
    cyc(RT, 3'b000, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc(RT, 3'b000, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00);
    cyc(RT, 3'b000, 0, 0, 1, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc(RT, 3'b000, 0, 0, 1, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
    // and (R, funct3=111)
    cyc(RT, 3'b111, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc(RT, 3'b111, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00);
    cyc(RT, 3'b111, 0, 0, 1, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 2'b00);
    cyc(RT, 3'b111, 0, 0, 1, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
    // addi with funct7b5=1 stays add (Op[5]=0)
    cyc(IT, 3'b000, 1, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc(IT, 3'b000, 1, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00);
    cyc(IT, 3'b000, 1, 0, 1, 0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00);
    cyc(IT, 3'b000, 1, 0, 1, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
    // slti, then ori on the last EXECUTEI cycle decode
    cyc(IT, 3'b010, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc(IT, 3'b010, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00);
    cyc(IT, 3'b110, 0, 0, 1, 0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 2'b00);
    cyc(IT, 3'b010, 0, 0, 1, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
    // beq taken
    cyc(BR, 3'b000, 0, 1, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00);
    cyc(BR, 3'b000, 0, 1, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 2'b00);
    cyc(BR, 3'b000, 0, 1, 1, 0, 4'd9, 5'b10000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 2'b10);
    // beq not taken
    cyc(BR, 3'b000, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00);
    cyc(BR, 3'b000, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 2'b00);
    cyc(BR, 3'b000, 0, 0, 1, 0, 4'd9, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 2'b10);
    // fetch stall 3 cycles, then jal with mem_ready low outside FETCH
    for (int i = 0; i < 3; i++)
      cyc(JP, 3'b000, 0, 0, 0, 0, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 2'b00);
    cyc(JP, 3'b000, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 2'b00);
    cyc(JP, 3'b000, 0, 0, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 2'b00);
    cyc(JP, 3'b000, 0, 0, 0, 0, 4'd10, 5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 2'b00);
    cyc(JP, 3'b000, 0, 0, 0, 0, 4'd8, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 2'b10);
    // sw with two wait cycles
    cyc(SW, 3'b010, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 0, 0, 4'd5, 5'b00011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 0, 0, 4'd5, 5'b00011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 1, 0, 4'd5, 5'b00011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b10);
    // sw aborted by reset inside MEMWRITE
    cyc(SW, 3'b010, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 0, 1, 4'd5, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00);
    cyc(SW, 3'b010, 0, 0, 0, 0, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    // illegal opcode -> TRAP, absorbing, cleared only by reset
    cyc(IL, 3'b000, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc(IL, 3'b000, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00);
    for (int i = 0; i < 10; i++)
      cyc(IL, 3'b000, 0, i[0], 1, 0, 4'd11, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    cyc(IL, 3'b000, 0, 0, 1, 1, 4'd11, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc(LW, 3'b000, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc(LW, 3'b000, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port Op, input, 7, instruction opcode Instr[6:0], taken from the instruction register.
REQ-004 SHALL have port funct3, input, 3, Instr[14:12].
REQ-005 SHALL have port funct7b5, input, 1, Instr[30].
REQ-006 SHALL have port Zero, input, 1, ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1, shared instruction/data memory access completes this cycle.
REQ-008 SHALL have ports PCWrite, IRWrite, RegWrite, MemWrite and AdrSrc, output, 1 each; AdrSrc selects the memory address (0=PC, 1=Result).
REQ-009 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, output, 2 each.
- ResultSrc: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA: 00=PC, 01=OldPC, 10=RD1.
- ALUSrcB: 00=RD2, 01=ImmExt, 10=4.
REQ-010 SHALL have port ALUControl, output, 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 SHALL have ports instr_done and illegal, output, 1 each; SHALL have port state, output, 4, debug.

Function
REQ-012 SHALL implement a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11. The current encoding SHALL be driven on state.
REQ-013 Every output not listed for a state SHALL be 0.
REQ-014 In FETCH the controller SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add and ResultSrc=10.
- IRWrite and PCWrite SHALL be 1 only when mem_ready=1.
- Transition to DECODE on mem_ready=1; otherwise stay in FETCH.
REQ-015 In DECODE the controller SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=add. Next state by Op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other value -> TRAP
REQ-016 ImmSrc SHALL be decoded from Op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
REQ-017 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=add. Next state: MEMREAD if Op=0000011, else MEMWRITE.
REQ-018 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, and stay until mem_ready=1, then go to MEMWB.
REQ-019 MEMWB SHALL drive ResultSrc=01, RegWrite=1, instr_done=1, then go to FETCH.
REQ-020 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1, holding MemWrite until mem_ready=1.
- instr_done=1 in the mem_ready cycle, then go to FETCH.
REQ-021 EXECUTER SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=funct, then go to ALUWB.
REQ-022 EXECUTEI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=funct, then go to ALUWB.
REQ-023 ALUWB SHALL drive ResultSrc=00, RegWrite=1, instr_done=1, then go to FETCH.
REQ-024 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, PCWrite=Zero, instr_done=1, then go to FETCH.
REQ-025 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-026 ALU decode SHALL follow these rules:
- ALUOp add -> 000; sub -> 001.
- funct mode by funct3: 000 -> 001 if (funct7b5 & Op[5]) else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
REQ-027 TRAP SHALL be absorbing until reset, with illegal=1 and all enables 0.
REQ-028 mem_ready SHALL be ignored in every state except FETCH, MEMREAD and MEMWRITE; there is no stall timeout.
REQ-029 Op/funct inputs SHALL be sampled only for next-state and output decode; the controller SHALL hold no instruction copy.

Reset
REQ-030 When rst=1 at a clk edge, state SHALL become FETCH from any state, TRAP and mid-MEMWRITE included.
REQ-031 While rst=1, PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal SHALL be forced to 0.
REQ-032 After reset release, the first FETCH SHALL behave per REQ-014.

Verification
REQ-033 lw (Op=0000011) with mem_ready=1 SHALL produce the state sequence 0,1,2,3,4,0; RegWrite=1 and instr_done=1 only in cycle 5.
REQ-034 sub (Op=0110011, funct3=000, funct7b5=1) SHALL give ALUControl=001 in EXECUTER; add with funct7b5=0 SHALL give 000. Both SHALL take 4 cycles.
REQ-035 beq with Zero=1 SHALL give PCWrite=1 in BEQ, with 3 cycles total; with Zero=0, PCWrite=0 in BEQ.
REQ-036 mem_ready held 0 for 3 cycles in FETCH SHALL keep IRWrite=PCWrite=0 and state=0 for 3 cycles, then 1 for one cycle when mem_ready=1.
REQ-037 Op=1111111 SHALL go to TRAP (state=11) with illegal=1 held for 10+ cycles; rst=1 SHALL then give state=0 and illegal=0.
REQ-038 sw with mem_ready=0 and rst asserted in MEMWRITE SHALL give MemWrite=0 in the rst cycle and state=0 on the next edge.
